// File: rtl/gray_sync_pkg.sv
// rtl/gray_sync_pkg.sv - shared types, mode encodings and Gray-code helpers for gray_sync_checker
package gray_sync_pkg;

    localparam int MAX_W = 64;

    localparam int MODE_PASS   = 0;
    localparam int MODE_FLAG   = 1;
    localparam int MODE_FILTER = 2;

    typedef enum logic {
        ACCEPT  = 1'b0,
        CONFIRM = 1'b1
    } check_state_e;

    // Operands are zero-extended to MAX_W, so the upper bits stay zero and any narrower width works.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    function automatic logic popcount_ge2(input logic [MAX_W-1:0] x);
        return |(x & (x - MAX_W'(1)));
    endfunction

endpackage

// File: rtl/gray_sync_checker_if.sv
// rtl/gray_sync_checker_if.sv - source-side Gray bus and synchronized/checked result bundle
interface gray_sync_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic [WIDTH-1:0]     async_gray;
    logic [WIDTH-1:0]     sync_gray;
    logic [WIDTH-1:0]     sync_bin;
    logic                 changed;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output async_gray,
        input  sync_gray,
        input  sync_bin,
        input  changed,
        input  err,
        input  err_cnt
    );

    modport slave (
        input  async_gray,
        output sync_gray,
        output sync_bin,
        output changed,
        output err,
        output err_cnt
    );
endinterface

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - bare multi-flop synchronizer chain with asynchronous active-low clear
module sync_chain #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_sync_checker.sv
// rtl/gray_sync_checker.sv - Gray-bus synchronizer with registered binary output and multi-bit change checking
module gray_sync_checker
    import gray_sync_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int STAGES     = 2,
    parameter int CHECK_MODE = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic               clk,
    input  logic               nrst,
    gray_sync_checker_if.slave bus
);

    if (STAGES < 2) begin : g_bad_stages
        $error("gray_sync_checker: STAGES must be >= 2");
    end
    if (WIDTH < 1 || WIDTH > MAX_W) begin : g_bad_width
        $error("gray_sync_checker: WIDTH out of range");
    end
    if (CHECK_MODE < MODE_PASS || CHECK_MODE > MODE_FILTER) begin : g_bad_mode
        $error("gray_sync_checker: CHECK_MODE must be 0, 1 or 2");
    end

    logic [WIDTH-1:0]     s;
    logic [WIDTH-1:0]     gray_q;
    logic [WIDTH-1:0]     bin_q;
    logic [WIDTH-1:0]     cand_q;
    logic [WIDTH-1:0]     cand_d;
    logic [WIDTH-1:0]     next_gray;
    logic [WIDTH-1:0]     next_bin;
    logic                 changed_q;
    logic                 changed_d;
    logic                 err_q;
    logic                 err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 diff_any;
    logic                 multi;
    check_state_e         state_q;
    check_state_e         state_d;

    sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_chain (
        .clk  (clk),
        .nrst (nrst),
        .d    (bus.async_gray),
        .q    (s)
    );

    // Distance is always measured against the accepted value, not the previous chain output.
    assign diff_any = (s != gray_q);
    assign multi    = popcount_ge2(MAX_W'(s ^ gray_q));
    assign next_bin = WIDTH'(gray2bin(MAX_W'(next_gray)));

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        next_gray = gray_q;
        changed_d = 1'b0;
        err_d     = 1'b0;
        if (CHECK_MODE != MODE_FILTER) begin
            next_gray = s;
            changed_d = diff_any;
            err_d     = (CHECK_MODE == MODE_FLAG) && multi;
            state_d   = ACCEPT;
        end else begin
            case (state_q)
                ACCEPT: begin
                    if (multi) begin
                        cand_d  = s;
                        err_d   = 1'b1;
                        state_d = CONFIRM;
                    end else if (diff_any) begin
                        next_gray = s;
                        changed_d = 1'b1;
                    end
                end
                CONFIRM: begin
                    // A repeated multi-bit value is a real jump from a faster source, not a glitch.
                    if (s == cand_q) begin
                        next_gray = cand_q;
                        changed_d = 1'b1;
                        state_d   = ACCEPT;
                    end else if (!diff_any) begin
                        state_d = ACCEPT;
                    end else if (!multi) begin
                        next_gray = s;
                        changed_d = 1'b1;
                        state_d   = ACCEPT;
                    end else begin
                        cand_d = s;
                        err_d  = 1'b1;
                    end
                end
                default: state_d = ACCEPT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ACCEPT;
            cand_q    <= '0;
            gray_q    <= '0;
            bin_q     <= '0;
            changed_q <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            gray_q    <= next_gray;
            bin_q     <= next_bin;
            changed_q <= changed_d;
            err_q     <= err_d;
            if (err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    assign bus.sync_gray = gray_q;
    assign bus.sync_bin  = bin_q;
    assign bus.changed   = changed_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gray_sync_checker.sv
// tb/tb_gray_sync_checker.sv - scoreboard bench over four configurations of gray_sync_checker
module tb_gray_sync_checker;

    typedef struct {
        int         cyc;
        logic [3:0] gray;
        logic [3:0] bin;
        logic       chg;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sbq [4][$];
    int   stg [4] = '{3, 2, 2, 2};

    gray_sync_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) bus0 ();
    gray_sync_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) bus1 ();
    gray_sync_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) bus2 ();
    gray_sync_checker_if #(.WIDTH(4), .ERR_CNT_W(2)) bus3 ();

    gray_sync_checker #(.WIDTH(4), .STAGES(3), .CHECK_MODE(0), .ERR_CNT_W(8))
        u_dut0 (.clk(clk), .nrst(nrst), .bus(bus0));
    gray_sync_checker #(.WIDTH(4), .STAGES(2), .CHECK_MODE(1), .ERR_CNT_W(8))
        u_dut1 (.clk(clk), .nrst(nrst), .bus(bus1));
    gray_sync_checker #(.WIDTH(4), .STAGES(2), .CHECK_MODE(2), .ERR_CNT_W(8))
        u_dut2 (.clk(clk), .nrst(nrst), .bus(bus2));
    gray_sync_checker #(.WIDTH(4), .STAGES(2), .CHECK_MODE(1), .ERR_CNT_W(2))
        u_dut3 (.clk(clk), .nrst(nrst), .bus(bus3));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_evt(input int id, input logic [3:0] g, input logic [3:0] b,
                             input logic c, input logic e, input logic [7:0] n);
        exp_t x;
        n_tests++;
        if (sbq[id].size() == 0) begin
            n_fail++;
            $display("FAIL evt_unexpected dut%0d cyc=%0d got gray=%b bin=%b chg=%b err=%b cnt=%0d, required no event",
                     id, cyc, g, b, c, e, n);
        end else begin
            x = sbq[id].pop_front();
            if (x.cyc != cyc || x.gray != g || x.bin != b || x.chg != c || x.err != e || x.cnt != n) begin
                n_fail++;
                $display("FAIL evt dut%0d got cyc=%0d gray=%b bin=%b chg=%b err=%b cnt=%0d, required cyc=%0d gray=%b bin=%b chg=%b err=%b cnt=%0d",
                         id, cyc, g, b, c, e, n, x.cyc, x.gray, x.bin, x.chg, x.err, x.cnt);
            end
        end
    endtask

    always @(negedge clk) if (bus0.changed || bus0.err)
        check_evt(0, bus0.sync_gray, bus0.sync_bin, bus0.changed, bus0.err, bus0.err_cnt);
    always @(negedge clk) if (bus1.changed || bus1.err)
        check_evt(1, bus1.sync_gray, bus1.sync_bin, bus1.changed, bus1.err, bus1.err_cnt);
    always @(negedge clk) if (bus2.changed || bus2.err)
        check_evt(2, bus2.sync_gray, bus2.sync_bin, bus2.changed, bus2.err, bus2.err_cnt);
    always @(negedge clk) if (bus3.changed || bus3.err)
        check_evt(3, bus3.sync_gray, bus3.sync_bin, bus3.changed, bus3.err, 8'(bus3.err_cnt));

    task automatic drive(input int id, input logic [3:0] g, output int c);
        @(negedge clk);
        case (id)
            0: bus0.async_gray = g;
            1: bus1.async_gray = g;
            2: bus2.async_gray = g;
            default: bus3.async_gray = g;
        endcase
        c = cyc;
    endtask

    // Expected event lands STAGES+1 edges after the drive, plus any confirm delay.
    task automatic push_exp(input int id, input int c, input int extra, input logic [3:0] g,
                            input logic [3:0] b, input logic ch, input logic e, input logic [7:0] n);
        exp_t x;
        x.cyc  = c + 1 + stg[id] + extra;
        x.gray = g;
        x.bin  = b;
        x.chg  = ch;
        x.err  = e;
        x.cnt  = n;
        sbq[id].push_back(x);
    endtask

    task automatic check_drained(input int id, input string nm);
        n_tests++;
        if (sbq[id].size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s dut%0d got %0d pending events, required 0", nm, id, sbq[id].size());
        end
    endtask

    task automatic check_zero(input string nm, input logic [3:0] g, input logic [3:0] b,
                              input logic c, input logic e, input logic [7:0] n);
        n_tests++;
        if (g !== 4'd0 || b !== 4'd0 || c !== 1'b0 || e !== 1'b0 || n !== 8'd0) begin
            n_fail++;
            $display("FAIL %s got gray=%b bin=%b chg=%b err=%b cnt=%0d, required all zero", nm, g, b, c, e, n);
        end
    endtask

    task automatic check_val(input string nm, input logic [7:0] got, input logic [7:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got %0h, required %0h", nm, got, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        bus0.async_gray = '0;
        bus1.async_gray = '0;
        bus2.async_gray = '0;
        bus3.async_gray = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int c;
        logic [3:0] t1_g [3] = '{4'b0001, 4'b0011, 4'b0010};
        logic [3:0] t1_b [3] = '{4'd1, 4'd2, 4'd3};
        logic [3:0] t6_g [5] = '{4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0011};
        logic [3:0] t6_b [5] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010};
        logic [7:0] t6_n [5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};

        bus0.async_gray = '0;
        bus1.async_gray = '0;
        bus2.async_gray = '0;
        bus3.async_gray = '0;
        repeat (3) @(negedge clk);
        check_zero("reset_dut0", bus0.sync_gray, bus0.sync_bin, bus0.changed, bus0.err, bus0.err_cnt);
        check_zero("reset_dut1", bus1.sync_gray, bus1.sync_bin, bus1.changed, bus1.err, bus1.err_cnt);
        check_zero("reset_dut2", bus2.sync_gray, bus2.sync_bin, bus2.changed, bus2.err, bus2.err_cnt);
        check_zero("reset_dut3", bus3.sync_gray, bus3.sync_bin, bus3.changed, bus3.err, 8'(bus3.err_cnt));
        nrst = 1'b1;
        repeat (3) @(negedge clk);

        // single-bit steps through mode 1
        for (int i = 0; i < 3; i++) begin
            drive(1, t1_g[i], c);
            push_exp(1, c, 0, t1_g[i], t1_b[i], 1'b1, 1'b0, 8'd0);
            repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check_drained(1, "steps");

        // three-stage latency, pass-through mode
        drive(0, 4'b0001, c);
        push_exp(0, c, 0, 4'b0001, 4'b0001, 1'b1, 1'b0, 8'd0);
        repeat (6) @(negedge clk);
        check_drained(0, "latency");

        // multi-bit jump in flag mode
        do_reset();
        drive(1, 4'b0110, c);
        push_exp(1, c, 0, 4'b0110, 4'b0100, 1'b1, 1'b1, 8'd1);
        repeat (6) @(negedge clk);
        check_drained(1, "jump");

        // filter mode: one-cycle glitch is dropped
        do_reset();
        drive(2, 4'b0101, c);
        push_exp(2, c, 0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd1);
        drive(2, 4'b0000, c);
        repeat (6) @(negedge clk);
        check_val("glitch_hold_gray", 8'(bus2.sync_gray), 8'h00);
        check_drained(2, "glitch");

        // filter mode: held jump confirmed one cycle after the error
        do_reset();
        drive(2, 4'b0101, c);
        push_exp(2, c, 0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd1);
        push_exp(2, c, 1, 4'b0101, 4'b0110, 1'b1, 1'b0, 8'd1);
        repeat (6) @(negedge clk);
        check_drained(2, "confirm");

        // saturating 2-bit error counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(3, t6_g[i], c);
            push_exp(3, c, 0, t6_g[i], t6_b[i], 1'b1, 1'b1, t6_n[i]);
            repeat (3) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check_drained(3, "saturate");
        check_val("pre_reset_gray", 8'(bus3.sync_gray), 8'h03);

        // asynchronous reset between edges
        @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check_zero("midreset_dut3", bus3.sync_gray, bus3.sync_bin, bus3.changed, bus3.err, 8'(bus3.err_cnt));
        bus3.async_gray = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);

        // Gray wrap is a single-bit change
        drive(3, 4'b1000, c);
        push_exp(3, c, 0, 4'b1000, 4'b1111, 1'b1, 1'b0, 8'd0);
        repeat (3) @(negedge clk);
        drive(3, 4'b0000, c);
        push_exp(3, c, 0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd0);
        repeat (6) @(negedge clk);
        check_drained(3, "wrap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
